// File: rtl/procesador_pkg.sv
// Shared encodings for the multicycle MIPS-subset core: FSM states, ALU ops,
// opcode/funct values and small decode helpers.
package procesador_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   function automatic logic funct_legal(input logic [5:0] funct);
      logic ok;
      ok = 1'b0;
      case (funct)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic instr_legal(input logic [31:0] instr);
      logic ok;
      ok = 1'b0;
      case (instr[31:26])
         OP_RTYPE: ok = funct_legal(instr[5:0]);
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
      alu_op_e op;
      op = ALU_ADD;
      case (funct)
         FN_SUB:  op = ALU_SUB;
         FN_AND:  op = ALU_AND;
         FN_OR:   op = ALU_OR;
         FN_SLT:  op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/banco_registros_p.sv
// General-purpose register file: two asynchronous read ports, one synchronous
// write port; entry 0 is never written so it always reads zero.
module banco_registros_p #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int IDX_W  = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  ra_addr_i,
   input  logic [IDX_W-1:0]  rb_addr_i,
   output logic [DATA_W-1:0] ra_data_o,
   output logic [DATA_W-1:0] rb_data_o,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i
);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [NREG-1:0]   wen;

   for (genvar gi = 0; gi < NREG; gi++) begin : g_wen
      assign wen[gi] = we_i && (waddr_i == IDX_W'(gi)) && (gi != 0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (wen[i]) regs_q[i] <= wdata_i;
         end
      end
   end

   assign ra_data_o = regs_q[ra_addr_i];
   assign rb_data_o = regs_q[rb_addr_i];

endmodule

// File: rtl/procesador_multiciclo.sv
// Multicycle MIPS-subset core: one FSM sequences fetch/decode/execute/memory/
// writeback over a shared ALU, with req/ready handshakes to external memories.
module procesador_multiciclo
   import procesador_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter int                NREG     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_ready,
   output logic              dmem_re,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic              halted,
   output logic              illegal,
   output logic [ADDR_W-1:0] pc_dbg
);

   localparam int IDX_W = $clog2(NREG);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [DATA_W-1:0] aluout_q, aluout_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              illegal_q, illegal_d;

   logic [5:0]        opcode;
   logic [IDX_W-1:0]  rs_idx, rt_idx, rd_idx;
   logic [DATA_W-1:0] imm_sext;
   logic [ADDR_W-1:0] br_target;
   logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;
   logic              rf_we;
   logic [IDX_W-1:0]  rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   alu_op_e           alu_op;
   logic [DATA_W-1:0] alu_b, alu_y;

   assign opcode    = ir_q[31:26];
   assign rs_idx    = ir_q[21 +: IDX_W];
   assign rt_idx    = ir_q[16 +: IDX_W];
   assign rd_idx    = ir_q[11 +: IDX_W];
   assign imm_sext  = DATA_W'($signed(ir_q[15:0]));
   // pc_q already points past the branch when DECODE computes the target
   assign br_target = pc_q + ADDR_W'($signed({ir_q[15:0], 2'b00}));

   banco_registros_p #(
      .DATA_W (DATA_W),
      .NREG   (NREG),
      .IDX_W  (IDX_W)
   ) u_banco (
      .clk       (clk),
      .reset     (reset),
      .ra_addr_i (rs_idx),
      .rb_addr_i (rt_idx),
      .ra_data_o (rf_rdata_a),
      .rb_data_o (rf_rdata_b),
      .we_i      (rf_we),
      .waddr_i   (rf_waddr),
      .wdata_i   (rf_wdata)
   );

   always_comb begin
      alu_op = (opcode == OP_RTYPE) ? funct_to_alu(ir_q[5:0]) : ALU_ADD;
      alu_b  = (opcode == OP_RTYPE) ? b_q : imm_sext;
      case (alu_op)
         ALU_ADD: alu_y = a_q + alu_b;
         ALU_SUB: alu_y = a_q - alu_b;
         ALU_AND: alu_y = a_q & alu_b;
         ALU_OR:  alu_y = a_q | alu_b;
         ALU_SLT: alu_y = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
         default: alu_y = a_q + alu_b;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (imem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (!instr_legal(ir_q) || opcode == OP_HALT) state_d = S_HALT;
            else if (opcode == OP_J)                      state_d = S_FETCH;
            else                                          state_d = S_EXEC;
         end
         S_EXEC: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM;
               OP_BEQ:       state_d = S_FETCH;
               default:      state_d = S_WB;
            endcase
         end
         S_MEM:    if (dmem_ready) state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   // Fetch request is masked while reset is held even though the state sits in FETCH
   always_comb begin
      imem_req = reset && (state_q == S_FETCH);
      dmem_re  = (state_q == S_MEM) && (opcode == OP_LW);
      dmem_we  = (state_q == S_MEM) && (opcode == OP_SW);
      halted   = (state_q == S_HALT);
      rf_we    = (state_q == S_WB);
      rf_waddr = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
      rf_wdata = (opcode == OP_LW) ? mdr_q : aluout_q;
   end

   always_comb begin
      pc_d      = pc_q;
      ir_d      = ir_q;
      mdr_d     = mdr_q;
      aluout_d  = aluout_q;
      a_d       = a_q;
      b_d       = b_q;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ready) begin
               ir_d = imem_rdata;
               pc_d = pc_q + ADDR_W'(4);
            end
         end
         S_DECODE: begin
            a_d       = rf_rdata_a;
            b_d       = rf_rdata_b;
            aluout_d  = DATA_W'(br_target);
            illegal_d = illegal_q | ~instr_legal(ir_q);
            if (opcode == OP_J) pc_d = {pc_q[ADDR_W-1:28], ir_q[25:0], 2'b00};
         end
         S_EXEC: begin
            if (opcode == OP_BEQ) begin
               if (a_q == b_q) pc_d = ADDR_W'(aluout_q);
            end else begin
               aluout_d = alu_y;
            end
         end
         S_MEM: begin
            if (dmem_ready && opcode == OP_LW) mdr_d = dmem_rdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         mdr_q     <= '0;
         aluout_q  <= '0;
         a_q       <= '0;
         b_q       <= '0;
         illegal_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         mdr_q     <= mdr_d;
         aluout_q  <= aluout_d;
         a_q       <= a_d;
         b_q       <= b_d;
         illegal_q <= illegal_d;
      end
   end

   assign imem_addr  = pc_q;
   assign dmem_addr  = ADDR_W'(aluout_q);
   assign dmem_wdata = b_q;
   assign illegal    = illegal_q;
   assign pc_dbg     = pc_q;

endmodule

// File: tb/tb_procesador_multiciclo.sv
// Directed bench for procesador_multiciclo: small programs run from a bench
// instruction memory, results observed through stores, fetch addresses and timing.
module tb_procesador_multiciclo;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int NREG   = 32;

   localparam logic [5:0] T_ADDI = 6'b001000, T_LW = 6'b100011, T_SW = 6'b101011;
   localparam logic [5:0] T_BEQ  = 6'b000100, T_J  = 6'b000010;
   localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101, F_SLT = 6'b101010;
   localparam logic [31:0] I_HALT = 32'hFC00_0000;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              imem_req, imem_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              dmem_re, dmem_we, dmem_ready;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata, dmem_rdata;
   logic              halted, illegal;
   logic [ADDR_W-1:0] pc_dbg;

   procesador_multiciclo #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NREG     (NREG),
      .RESET_PC (32'h0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ready (imem_ready),
      .dmem_re    (dmem_re),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ready (dmem_ready),
      .halted     (halted),
      .illegal    (illegal),
      .pc_dbg     (pc_dbg)
   );

   always #5 clk = ~clk;

   logic [31:0] imem [64];
   logic [31:0] dmem [64];
   assign imem_rdata = imem[imem_addr[7:2]];

   int          n_cmp = 0, n_bad = 0;
   int          cyc = 0, dmem_delay = 0, wait_cnt = 0, stable_err = 0, halt_cyc = -1;
   logic [31:0] held_addr, held_wdata;
   logic [31:0] f_addr [$];
   int          f_cyc [$];
   logic [31:0] s_addr [$];
   logic [31:0] s_data [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   // Memory responder and event log; cycle 0 is the first FETCH after reset release
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            wait_cnt   = 0;
            dmem_ready = 1'b0;
         end else begin
            if (imem_req && imem_ready) begin
               f_addr.push_back(imem_addr);
               f_cyc.push_back(cyc);
            end
            if (halted && halt_cyc < 0) halt_cyc = cyc;
            if (dmem_re || dmem_we) begin
               if (wait_cnt == 0) begin
                  held_addr  = dmem_addr;
                  held_wdata = dmem_wdata;
               end else if (dmem_addr != held_addr || (dmem_we && dmem_wdata != held_wdata)) begin
                  stable_err++;
               end
               if (wait_cnt >= dmem_delay) begin
                  dmem_ready = 1'b1;
                  if (dmem_we) begin
                     dmem[dmem_addr[7:2]] = dmem_wdata;
                     s_addr.push_back(dmem_addr);
                     s_data.push_back(dmem_wdata);
                  end else begin
                     dmem_rdata = dmem[dmem_addr[7:2]];
                  end
               end else begin
                  dmem_ready = 1'b0;
               end
               wait_cnt++;
            end else begin
               dmem_ready = 1'b0;
               wait_cnt   = 0;
            end
            cyc++;
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) begin
         imem[i] = I_HALT;
         dmem[i] = 32'h0;
      end
   endtask

   task automatic start_run(input int delay);
      reset      = 1'b0;
      dmem_delay = delay;
      f_addr.delete();
      f_cyc.delete();
      s_addr.delete();
      s_data.delete();
      halt_cyc   = -1;
      stable_err = 0;
      repeat (2) @(posedge clk);
      cyc = 0;
      #1 reset = 1'b1;
   endtask

   task automatic wait_halt(input int budget);
      int n;
      n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("halt_reached", 32'(halted), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   function automatic logic [31:0] fcyc_delta(input int idx);
      if (f_cyc.size() > idx) return 32'(f_cyc[idx] - f_cyc[idx-1]);
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] sdata_at(input int idx);
      if (s_data.size() > idx) return s_data[idx];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] saddr_at(input int idx);
      if (s_addr.size() > idx) return s_addr[idx];
      return 32'hDEAD_BEEF;
   endfunction

   typedef struct {
      logic [31:0] op_instr;
      logic [15:0] a;
      logic [15:0] b;
      int          st_reg;
      logic [31:0] exp;
   } alu_vec_t;

   alu_vec_t    vecs [13];
   logic [31:0] exp_pc [9];

   initial begin
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      dmem_rdata = '0;

      vecs[0]  = '{enc_r(3, 1, 2, F_ADD), 16'h0005, 16'hFFFD, 3, 32'h0000_0002};
      vecs[1]  = '{enc_r(3, 1, 2, F_SUB), 16'h0005, 16'hFFFD, 3, 32'h0000_0008};
      vecs[2]  = '{enc_r(3, 2, 1, F_SUB), 16'h0005, 16'hFFFD, 3, 32'hFFFF_FFF8};
      vecs[3]  = '{enc_r(3, 1, 2, F_AND), 16'h0FF0, 16'h3C3C, 3, 32'h0000_0C30};
      vecs[4]  = '{enc_r(3, 1, 2, F_AND), 16'hFFFF, 16'h1234, 3, 32'h0000_1234};
      vecs[5]  = '{enc_r(3, 1, 2, F_OR),  16'h00F0, 16'h8000, 3, 32'hFFFF_80F0};
      vecs[6]  = '{enc_r(3, 2, 1, F_SLT), 16'h0005, 16'hFFFD, 3, 32'h0000_0001};
      vecs[7]  = '{enc_r(3, 1, 2, F_SLT), 16'h0005, 16'hFFFD, 3, 32'h0000_0000};
      vecs[8]  = '{enc_r(3, 1, 2, F_SLT), 16'h0007, 16'h0007, 3, 32'h0000_0000};
      vecs[9]  = '{enc_r(3, 1, 2, F_ADD), 16'hFFFF, 16'h0001, 3, 32'h0000_0000};
      vecs[10] = '{enc_r(0, 1, 1, F_ADD), 16'h0005, 16'hFFFD, 0, 32'h0000_0000};
      vecs[11] = '{enc_i(T_ADDI, 3, 1, -10), 16'h0005, 16'h0000, 3, 32'hFFFF_FFFB};
      vecs[12] = '{enc_r(3, 1, 2, F_OR),  16'h1234, 16'h4321, 3, 32'h0000_5335};

      // Reset state
      clear_mem();
      #12;
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_dmem_re",  32'(dmem_re),  32'd0);
      check("rst_dmem_we",  32'(dmem_we),  32'd0);
      check("rst_halted",   32'(halted),   32'd0);
      check("rst_illegal",  32'(illegal),  32'd0);
      check("rst_pc",       pc_dbg,        32'h0);

      // ALU / writeback table: r1=a, r2=b, op, store result to 0(r0)
      for (int v = 0; v < 13; v++) begin
         clear_mem();
         imem[0] = enc_i(T_ADDI, 1, 0, int'($signed(vecs[v].a)));
         imem[1] = enc_i(T_ADDI, 2, 0, int'($signed(vecs[v].b)));
         imem[2] = vecs[v].op_instr;
         imem[3] = enc_i(T_SW, vecs[v].st_reg, 0, 0);
         start_run(0);
         wait_halt(100);
         $display("vec %0d: instr=0x%08h a=0x%04h b=0x%04h stored=0x%08h expected=0x%08h",
                  v, vecs[v].op_instr, vecs[v].a, vecs[v].b, sdata_at(0), vecs[v].exp);
         check("vec_store_cnt", 32'(s_data.size()), 32'd1);
         check("vec_result",    sdata_at(0),       vecs[v].exp);
         check("vec_store_addr", saddr_at(0),      32'h0);
         check("vec_op_latency", fcyc_delta(3),    32'd4);
         check("vec_illegal",   32'(illegal),      32'd0);
      end

      // Timing of addi, addi, add, halt: halted seen in cycle 4+4+4+3 (index 14)
      clear_mem();
      imem[0] = enc_i(T_ADDI, 1, 0, 5);
      imem[1] = enc_i(T_ADDI, 2, 0, -3);
      imem[2] = enc_r(3, 1, 2, F_ADD);
      start_run(0);
      wait_halt(100);
      $display("t1: halt_cyc=%0d fetches=%0d illegal=%0b", halt_cyc, f_addr.size(), illegal);
      check("t1_halt_cycle", 32'(halt_cyc),       32'd14);
      check("t1_illegal",    32'(illegal),        32'd0);
      check("t1_fetch_cnt",  32'(f_addr.size()),  32'd4);
      check("t1_addi_lat",   fcyc_delta(1),       32'd4);
      check("t1_add_lat",    fcyc_delta(3),       32'd4);
      check("t1_no_req",     32'(imem_req),       32'd0);

      // Store then load with dmem_ready delayed two cycles
      clear_mem();
      imem[0] = enc_i(T_ADDI, 1, 0, 5);
      imem[1] = enc_i(T_SW, 1, 0, 8);
      imem[2] = enc_i(T_LW, 4, 0, 8);
      imem[3] = enc_i(T_SW, 4, 0, 12);
      start_run(2);
      wait_halt(150);
      $display("t2: stores=%0d sw_lat=%0d lw_lat=%0d", s_data.size(), fcyc_delta(2), fcyc_delta(3));
      check("t2_store_cnt", 32'(s_data.size()), 32'd2);
      check("t2_sw_addr",   saddr_at(0),        32'd8);
      check("t2_sw_data",   sdata_at(0),        32'd5);
      check("t2_lw_result", sdata_at(1),        32'd5);
      check("t2_sw_lat",    fcyc_delta(2),      32'd6);
      check("t2_lw_lat",    fcyc_delta(3),      32'd7);
      check("t2_stable",    32'(stable_err),    32'd0);

      // Taken beq at 0x10, not-taken beq at 0x1C, then j to 0x30
      clear_mem();
      imem[0]  = enc_i(T_ADDI, 1, 0, 5);
      imem[1]  = enc_i(T_ADDI, 2, 0, -3);
      imem[2]  = enc_i(T_ADDI, 6, 0, 1);
      imem[3]  = enc_i(T_ADDI, 6, 0, 2);
      imem[4]  = enc_i(T_BEQ, 1, 1, 2);
      imem[5]  = enc_i(T_SW, 1, 0, 32'h40);
      imem[6]  = enc_i(T_SW, 2, 0, 32'h44);
      imem[7]  = enc_i(T_BEQ, 2, 1, 5);
      imem[8]  = {T_J, 26'd12};
      imem[9]  = enc_i(T_SW, 1, 0, 32'h48);
      imem[12] = enc_i(T_SW, 6, 0, 32'h4C);
      exp_pc = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h20, 32'h30, 32'h34};
      start_run(0);
      wait_halt(150);
      check("t3_fetch_cnt", 32'(f_addr.size()), 32'd9);
      for (int k = 0; k < 9; k++) begin
         logic [31:0] got;
         got = (f_addr.size() > k) ? f_addr[k] : 32'hDEAD_BEEF;
         $display("t3: fetch %0d at 0x%08h, expected 0x%08h", k, got, exp_pc[k]);
         check("t3_fetch_pc", got, exp_pc[k]);
      end
      check("t3_beq_taken_lat", fcyc_delta(5), 32'd3);
      check("t3_beq_not_lat",   fcyc_delta(6), 32'd3);
      check("t3_store_cnt", 32'(s_data.size()), 32'd1);
      check("t3_store_addr", saddr_at(0),       32'h4C);
      check("t3_store_data", sdata_at(0),       32'd2);

      // Undecoded opcode 0x3E stops the core
      clear_mem();
      imem[0] = enc_i(T_ADDI, 1, 0, 1);
      imem[1] = 32'hF800_0000;
      imem[2] = enc_i(T_SW, 1, 0, 0);
      start_run(0);
      wait_halt(100);
      repeat (5) @(negedge clk);
      $display("t5: illegal=%0b fetches=%0d pc=0x%08h", illegal, f_addr.size(), pc_dbg);
      check("t5_illegal",   32'(illegal),       32'd1);
      check("t5_fetch_cnt", 32'(f_addr.size()), 32'd2);
      check("t5_no_req",    32'(imem_req),      32'd0);
      check("t5_no_store",  32'(s_data.size()), 32'd0);
      check("t5_pc",        pc_dbg,             32'h8);

      // Undecoded R-type funct
      clear_mem();
      imem[0] = enc_r(3, 1, 2, 6'b000000);
      start_run(0);
      wait_halt(100);
      $display("t5b: illegal=%0b", illegal);
      check("t5b_illegal", 32'(illegal), 32'd1);

      // Reset pulsed during the MEM wait of a lw
      clear_mem();
      imem[0] = enc_i(T_SW, 4, 0, 16);
      imem[1] = enc_i(T_LW, 4, 0, 8);
      imem[2] = enc_i(T_SW, 4, 0, 20);
      dmem[2] = 32'h0000_00AB;
      start_run(6);
      begin
         int n;
         n = 0;
         while (!dmem_re && n < 80) begin
            @(negedge clk);
            n++;
         end
      end
      @(negedge clk);
      check("t6_re_before", 32'(dmem_re), 32'd1);
      #1 reset = 1'b0;
      #1;
      $display("t6: after reset dmem_re=%0b imem_req=%0b pc=0x%08h", dmem_re, imem_req, pc_dbg);
      check("t6_re_drop",  32'(dmem_re),  32'd0);
      check("t6_req_low",  32'(imem_req), 32'd0);
      check("t6_pc_reset", pc_dbg,        32'h0);
      start_run(0);
      wait_halt(100);
      check("t6_first_fetch", (f_addr.size() > 0) ? f_addr[0] : 32'hDEAD_BEEF, 32'h0);
      check("t6_store_cnt",   32'(s_data.size()), 32'd2);
      check("t6_rt_unchanged", sdata_at(0),       32'h0);
      check("t6_lw_after",     sdata_at(1),       32'h0000_00AB);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
